// File: rtl/usb_rx_stage_counter.sv
// usb_rx_stage_counter
//
// Multi-stage bit/byte counter for the USB RX datapath. The counter walks through NUM_STAGES
// stages. Each stage counts 1..L(s), where L(s) is a run-time limit and a limit of 0 is
// treated as 1. After the last stage the counter either wraps to stage 0 or stops and raises
// a sticky done. All outputs are registered, so no input reaches an output combinationally.
//
// Ports:
//   clk           rising-edge system clock
//   n_rst         asynchronous active-low reset
//   clear         synchronous restart to stage 0 / count 0 (beats count_enable)
//   count_enable  advance the counter by one this cycle
//   stage_limits  packed per-stage limits, stage i at [i*SIZE +: SIZE]
//   flag_mask     bit i allows rollover_flag while in stage i
//   wrap_en       1: wrap to stage 0 after the last stage, 0: stop and set done
//   count_out     count within the current stage
//   stage_out     current stage index
//   rollover_flag count_out is at the current stage limit and that stage is unmasked
//   stage_adv     one-cycle pulse in the first cycle of a new stage
//   done          sticky end-of-sequence indication, cleared only by clear or reset
module usb_rx_stage_counter #(
  parameter int unsigned SIZE       = 5,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned STAGE_W    = 2
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         clear,
  input  logic                         count_enable,
  input  logic [NUM_STAGES*SIZE-1:0]   stage_limits,
  input  logic [NUM_STAGES-1:0]        flag_mask,
  input  logic                         wrap_en,
  output logic [SIZE-1:0]              count_out,
  output logic [STAGE_W-1:0]           stage_out,
  output logic                         rollover_flag,
  output logic                         stage_adv,
  output logic                         done
);

  localparam logic [STAGE_W-1:0] LastStage = STAGE_W'(NUM_STAGES - 1);
  localparam logic [SIZE-1:0]    OneCount  = SIZE'(1);

  logic [SIZE-1:0]    count_q, count_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic               flag_q, flag_d;
  logic               adv_q, adv_d;
  logic               done_q, done_d;

  // Per-stage limits with 0 clamped to 1, so every stage lasts at least one cycle.
  logic [SIZE-1:0] lim_arr [NUM_STAGES];

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_lim
    logic [SIZE-1:0] raw;
    assign raw        = stage_limits[g*SIZE +: SIZE];
    assign lim_arr[g] = (raw == '0) ? OneCount : raw;
  end

  // Limit and mask of the current stage. A loop compare keeps unreachable stage codes from
  // indexing past the array; they simply select nothing.
  logic [SIZE-1:0] lim_cur;
  logic            mask_cur;

  always_comb begin
    lim_cur  = OneCount;
    mask_cur = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_q == STAGE_W'(i)) begin
        lim_cur  = lim_arr[i];
        mask_cur = flag_mask[i];
      end
    end
  end

  // Limit and mask of the stage being entered next cycle, used for the registered flag.
  logic [SIZE-1:0] lim_nxt;
  logic            mask_nxt;

  always_comb begin
    lim_nxt  = OneCount;
    mask_nxt = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_d == STAGE_W'(i)) begin
        lim_nxt  = lim_arr[i];
        mask_nxt = flag_mask[i];
      end
    end
  end

  logic at_limit;
  logic is_last;

  // ">=" rather than "==" so a limit lowered below the running count still ends the stage.
  assign at_limit = (count_q >= lim_cur);
  assign is_last  = (stage_q == LastStage);

  // Next count / stage / adv / done.
  always_comb begin
    count_d = count_q;
    stage_d = stage_q;
    adv_d   = 1'b0;
    done_d  = done_q;

    if (clear) begin
      count_d = '0;
      stage_d = '0;
      done_d  = 1'b0;
    end else if (done_q) begin
      // Parked at end of sequence until clear.
    end else if (count_enable) begin
      if (!at_limit) begin
        count_d = count_q + OneCount;
      end else if (!is_last) begin
        stage_d = stage_q + STAGE_W'(1);
        count_d = OneCount;
        adv_d   = 1'b1;
      end else if (wrap_en) begin
        stage_d = '0;
        count_d = OneCount;
        adv_d   = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  // Next rollover flag. Evaluated against the state being entered so that a limit-1 stage
  // shows the flag in its very first cycle.
  always_comb begin
    flag_d = 1'b0;
    if (clear || done_q) begin
      flag_d = 1'b0;
    end else begin
      flag_d = (count_d == lim_nxt) && mask_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      stage_q <= '0;
      flag_q  <= 1'b0;
      adv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      stage_q <= stage_d;
      flag_q  <= flag_d;
      adv_q   <= adv_d;
      done_q  <= done_d;
    end
  end

  assign count_out     = count_q;
  assign stage_out     = stage_q;
  assign rollover_flag = flag_q;
  assign stage_adv     = adv_q;
  assign done          = done_q;

endmodule

// File: doc/usb_rx_stage_counter.md
Name: usb_rx_stage_counter

Overview:
Parametrised multi-stage bit/byte counter for the USB RX datapath. It generalises the fixed 4/8/8/5 stage sequence to NUM_STAGES stages. Each stage has a run-time rollover limit and a per-stage flag mask, with optional wrap after the last stage and a sticky done indication. The RX controller uses it to time sync, PID and payload byte boundaries and to detect end-of-sequence.

Parameters:
SIZE, 5, width of count_out and of each stage limit
NUM_STAGES, 4, number of stages in the sequence (>=2)
STAGE_W, 2, width of stage_out; must satisfy 2**STAGE_W >= NUM_STAGES

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous restart to stage 0, count 0; has priority over count_enable
count_enable  input  1  advance the counter by one this cycle
stage_limits  input  NUM_STAGES*SIZE  packed rollover limits; stage i uses bits [i*SIZE +: SIZE]
flag_mask  input  NUM_STAGES  bit i enables rollover_flag while in stage i
wrap_en  input  1  1: after the last stage, return to stage 0; 0: stop and set done
count_out  output  SIZE  count within the current stage (registered)
stage_out  output  STAGE_W  current stage index (registered)
rollover_flag  output  1  registered; high while count_out equals the current stage limit and that stage's mask bit is set
stage_adv  output  1  one-cycle registered pulse in the first cycle of a new stage
done  output  1  sticky; set when the last stage completes with wrap_en=0

Behaviour:
- Reset (n_rst=0, asynchronous): count_out=0, stage_out=0, rollover_flag=0, stage_adv=0, done=0.
- Effective limit L(s) = stage_limits[s]. A value of 0 is clamped to 1.
- Limits, mask and wrap_en are sampled combinationally each cycle. They are not latched.
- Priority: clear > done-hold > count_enable > idle.
- clear=1: next count=0, stage=0, rollover_flag=0, stage_adv=0, done=0, regardless of count_enable.
- done=1 and clear=0: all state holds. count_enable is ignored. rollover_flag=0, stage_adv=0.
- count_enable=1 with count_out < L(stage): count_out+1. stage unchanged. stage_adv=0.
- count_enable=1 with count_out >= L(stage) (at the limit, or the limit was lowered below count):
  - Stage not last: stage+1, count=1, stage_adv=1.
  - Last stage with wrap_en=1: stage=0, count=1, stage_adv=1.
  - Last stage with wrap_en=0: count and stage hold, done=1, stage_adv=0.
- Flag rule (all enabled transitions): next rollover_flag = (next count == L(next stage)) && flag_mask[next stage]. Consequence: a stage with limit 1 raises the flag in its first cycle.
- count_enable=0 (not clear, not done): state holds. stage_adv=0. rollover_flag is recomputed from the held count, stage and current mask/limits, so it stays high while parked at a masked limit.
- Latency: one clock from count_enable to updated count_out, stage_out and flags. No combinational path from inputs to outputs.
- Counter arithmetic is SIZE-bit unsigned. Limits up to 2**SIZE-1 are legal, and the count never exceeds the active limit through increment.
- Reset mid-operation takes effect immediately, independent of clk.
- Stage indices >= NUM_STAGES are unreachable.

Test Plan:
1. Reset, then limits {s0=4,s1=8,s2=8,s3=5}, mask=4'b0111, wrap_en=0, count_enable held high -> count 1..4 in stage 0 with flag high at count=4. Next cycle stage 1, count=1, stage_adv=1. Flag high at count=8 in stages 1 and 2. Stage 3 counts to 5 with flag low. Next enable sets done=1, with count=5 and stage=3 held.
2. Same limits, wrap_en=1 -> after stage 3 count=5, the next enable gives stage=0, count=1, stage_adv=1, done stays 0. The sequence repeats with identical timing.
3. Assert clear and count_enable together in stage 2, count=6 -> next cycle count=0, stage=0, all flags 0, done 0. The following enable gives count=1.
4. Gap test: drop count_enable for 3 cycles at stage 1, count=8 -> count, stage and rollover_flag=1 hold, stage_adv stays 0. Re-enable gives stage 2, count=1.
5. Limit corner: s1=0 (clamped to 1), mask bit1=1 -> on entry to stage 1, count=1 with rollover_flag=1 and stage_adv=1 in the same cycle. The next enable moves to stage 2.
6. Async reset pulsed mid-stage 2 between clock edges -> all outputs 0 immediately. Counting resumes from count=1 at stage 0 after release.
